tiny32_sram_responder: RTL and testbench
========================================

Name: tiny32_sram_responder

Overview:
- Bus responder (target end) for the tiny32 CPU memory bus.
- Accepts word read/write requests from the CPU and executes each one as four sequential byte cycles on an external 8-bit asynchronous SRAM.
- Stalls the CPU with ready while the byte cycles run.
- Sits beside the ROM/RAM decode; address decode is external and arrives on sel.

Parameters:
- SRAM_ABITS, 19, SRAM byte-address width.
- WAIT_CYCLES, 1, SRAM strobe-active clocks per byte (0..15). Slot length S = WAIT_CYCLES+2.

Ports:
- clk  input  1  system clock; all state changes on the rising edge
- nreset  input  1  asynchronous, active-low reset
- sel  input  1  external decode: this target addressed
- address  input  32  CPU byte address; bits [1:0] ignored
- nrd  input  1  active-low read strobe
- nwr  input  4  active-low byte-lane write strobes; lane i = data bits [8i+7:8i]
- data_in  input  32  CPU write data
- data_out  output  32  read data to CPU
- ready  output  1  transfer-complete pulse
- sram_addr  output  SRAM_ABITS  byte address
- sram_dq_out  output  8  write data
- sram_dq_in  input  8  read data
- sram_dq_oe  output  1  1 = drive the SRAM data bus
- sram_nce, sram_noe, sram_nwe  output  1 each  active-low SRAM controls

Behaviour:
Reset (async, nreset=0):
- state = IDLE; ready = 0; data_out = 0; sram_addr = 0; sram_dq_out = 0.
- sram_dq_oe = 0; sram_nce = sram_noe = sram_nwe = 1.
- Reset asserted mid-access aborts immediately. Outputs go to reset values with no partial completion.

Request detection in IDLE:
- A request is sampled when sel=1 and (nrd=0 or nwr!=4'b1111).
- If any nwr lane is low, the request is a write, even if nrd=0 at the same time.
- On acceptance, latch address[SRAM_ABITS-1:2], data_in, nwr and the write/read type.
- Later changes to these inputs are ignored until the next acceptance.
- sel=0 means no action.

State machine (all outputs registered):
- IDLE -> ACCESS on acceptance.
- ACCESS runs lanes 0,1,2,3 in order, S clocks each. sram_addr = {latched_word, lane[1:0]}. sram_nce = 0 for the whole of ACCESS.
- Read slot:
  - sram_noe = 0 for all S clocks; dq_oe = 0.
  - sram_dq_in is captured into data_out[8*lane+7:8*lane] on the last clock of the slot.
- Write slot, enabled lane (latched nwr[lane]=0):
  - dq_oe = 1 and sram_dq_out = lane byte for all S clocks.
  - sram_nwe: high on clock 1 (setup), low for WAIT_CYCLES clocks, high on the last clock (hold).
  - With WAIT_CYCLES=0 there is no nwe pulse. This is legal but a no-op; document it for integrators.
- Write slot, disabled lane: still consumes S clocks with nwe high, so latency is constant.
- ACCESS -> DONE after lane 3 completes.
- DONE: one clock with ready = 1. For reads, data_out is valid and stays stable until the next read completes. nce, noe and nwe are all 1; dq_oe = 0.
- DONE -> RELEASE: ready = 0; wait for nrd=1 and nwr=4'b1111, then go to IDLE. This prevents a held strobe from re-executing.
  - If the strobes are already released in DONE, RELEASE still lasts one clock.

Timing:
- Latency from the accepting edge to the ready=1 edge = 4*S+1 clocks (13 for the defaults).
- Write data_out is unchanged by writes.
- address[1:0] does not affect the lane order.

Test Plan:
- Reset, then idle with sel=1, nrd=1, nwr=F -> ready stays 0, all SRAM controls high, data_out=0.
- Preload SRAM bytes 0x100..0x103 = 11,22,33,44; read address 0x100 with WAIT_CYCLES=1 -> sram_addr steps 0x100..0x103 every 3 clocks; ready pulses exactly once, 13 clocks after acceptance; data_out=0x44332211.
- Write data_in=0xAABBCCDD with nwr=4'b1010 to address 0x200 -> nwe pulses only at 0x200 (DD) and 0x202 (BB); 0x201/0x203 unchanged; ready once after 13 clocks.
- Hold nrd low for 20 clocks after ready -> exactly one transaction, no second ready; then release and re-request -> a second transaction runs.
- nrd=0 and nwr=4'b1110 together with data_in=0x5A -> treated as a write: byte 0 = 0x5A, noe never low.
- Pull nreset low at clock 5 of ACCESS -> nce/nwe/noe high and dq_oe=0 immediately; after release, a read of the same address completes normally.
- sel=0 with nrd=0 -> no SRAM activity, ready stays 0.

Source files
------------

// File: rtl/tiny32_sram_responder.sv
// rtl/tiny32_sram_responder.sv - tiny32 bus target running each word access as four byte cycles on an 8-bit async SRAM
//
// Integrator note: WAIT_CYCLES=0 is accepted but produces no sram_nwe low
// pulse, so writes become no-ops. Use WAIT_CYCLES >= 1 for real SRAM.
module tiny32_sram_responder #(
    parameter int SRAM_ABITS  = 19,
    parameter int WAIT_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  nreset,
    input  logic                  sel,
    input  logic [31:0]           address,
    input  logic                  nrd,
    input  logic [3:0]            nwr,
    input  logic [31:0]           data_in,
    output logic [31:0]           data_out,
    output logic                  ready,
    output logic [SRAM_ABITS-1:0] sram_addr,
    output logic [7:0]            sram_dq_out,
    input  logic [7:0]            sram_dq_in,
    output logic                  sram_dq_oe,
    output logic                  sram_nce,
    output logic                  sram_noe,
    output logic                  sram_nwe
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } state_t;

    // Slot counter runs 0..SLOT_LAST; nwe is low for counts 1..WAIT_LAST.
    localparam logic [4:0] SLOT_LAST = 5'(WAIT_CYCLES + 1);
    localparam logic [4:0] WAIT_LAST = 5'(WAIT_CYCLES);

    state_t                  state_q, state_d;
    logic [1:0]              lane_q, lane_d;
    logic [4:0]              cnt_q, cnt_d;
    logic [SRAM_ABITS-3:0]   word_q, word_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              nwr_q, nwr_d;
    logic                    is_wr_q, is_wr_d;
    logic                    cap_q, cap_d;
    logic [1:0]              cap_lane_q, cap_lane_d;
    logic [31:0]             data_out_q, data_out_d;
    logic                    ready_q, ready_d;
    logic [SRAM_ABITS-1:0]   sram_addr_q, sram_addr_d;
    logic [7:0]              dq_out_q, dq_out_d;
    logic                    dq_oe_q, dq_oe_d;
    logic                    nce_q, nce_d;
    logic                    noe_q, noe_d;
    logic                    nwe_q, nwe_d;

    logic                    req;
    logic                    unused_addr_bits;

    assign req              = sel && (!nrd || (nwr != 4'hF));
    assign unused_addr_bits = ^{address[31:SRAM_ABITS], address[1:0]};

    // Sequencing: request capture, lane/slot counters and state transitions.
    always_comb begin
        state_d = state_q;
        lane_d  = lane_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        wdata_d = wdata_q;
        nwr_d   = nwr_q;
        is_wr_d = is_wr_q;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCESS;
                    lane_d  = 2'd0;
                    cnt_d   = 5'd0;
                    word_d  = address[SRAM_ABITS-1:2];
                    wdata_d = data_in;
                    nwr_d   = nwr;
                    // Any low write lane wins over a simultaneous read strobe.
                    is_wr_d = (nwr != 4'hF);
                end
            end
            ACCESS: begin
                if (cnt_q == SLOT_LAST) begin
                    cnt_d = 5'd0;
                    if (lane_q == 2'd3) begin
                        state_d = DONE;
                    end else begin
                        lane_d = lane_q + 2'd1;
                    end
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end
            DONE: begin
                state_d = RELEASE;
            end
            RELEASE: begin
                // Held strobes must drop before another access is accepted.
                if (nrd && (nwr == 4'hF)) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output stage: strobes derived from current state, so the pins lag the
    // sequencer by one clock; read bytes are taken at the end of each slot.
    always_comb begin
        ready_d     = 1'b0;
        nce_d       = 1'b1;
        noe_d       = 1'b1;
        nwe_d       = 1'b1;
        dq_oe_d     = 1'b0;
        dq_out_d    = dq_out_q;
        sram_addr_d = sram_addr_q;
        cap_d       = 1'b0;
        cap_lane_d  = lane_q;
        data_out_d  = data_out_q;
        if (cap_q) begin
            data_out_d[{cap_lane_q, 3'b000} +: 8] = sram_dq_in;
        end
        unique case (state_q)
            ACCESS: begin
                nce_d       = 1'b0;
                sram_addr_d = {word_q, lane_q};
                if (!is_wr_q) begin
                    noe_d = 1'b0;
                    cap_d = (cnt_q == SLOT_LAST);
                end else if (!nwr_q[lane_q]) begin
                    dq_oe_d  = 1'b1;
                    dq_out_d = wdata_q[{lane_q, 3'b000} +: 8];
                    nwe_d    = !((cnt_q != 5'd0) && (cnt_q <= WAIT_LAST));
                end
            end
            DONE: begin
                ready_d = 1'b1;
            end
            default: ;
        endcase
    end

    // State and registered outputs; reset aborts any access immediately.
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= IDLE;
            lane_q      <= 2'd0;
            cnt_q       <= 5'd0;
            word_q      <= '0;
            wdata_q     <= 32'd0;
            nwr_q       <= 4'hF;
            is_wr_q     <= 1'b0;
            cap_q       <= 1'b0;
            cap_lane_q  <= 2'd0;
            data_out_q  <= 32'd0;
            ready_q     <= 1'b0;
            sram_addr_q <= '0;
            dq_out_q    <= 8'd0;
            dq_oe_q     <= 1'b0;
            nce_q       <= 1'b1;
            noe_q       <= 1'b1;
            nwe_q       <= 1'b1;
        end else begin
            state_q     <= state_d;
            lane_q      <= lane_d;
            cnt_q       <= cnt_d;
            word_q      <= word_d;
            wdata_q     <= wdata_d;
            nwr_q       <= nwr_d;
            is_wr_q     <= is_wr_d;
            cap_q       <= cap_d;
            cap_lane_q  <= cap_lane_d;
            data_out_q  <= data_out_d;
            ready_q     <= ready_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            nce_q       <= nce_d;
            noe_q       <= noe_d;
            nwe_q       <= nwe_d;
        end
    end

    assign data_out    = data_out_q;
    assign ready       = ready_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_nce    = nce_q;
    assign sram_noe    = noe_q;
    assign sram_nwe    = nwe_q;

endmodule

// File: tb/tb_tiny32_sram_responder.sv
// tb/tb_tiny32_sram_responder.sv - scoreboard bench for tiny32_sram_responder
module tb_tiny32_sram_responder;

    localparam int S       = 3;
    localparam int LATENCY = 4 * S + 1;

    logic        clk;
    logic        nreset;
    logic        sel;
    logic [31:0] address;
    logic        nrd;
    logic [3:0]  nwr;
    logic [31:0] data_in;
    logic [31:0] data_out;
    logic        ready;
    logic [18:0] sram_addr;
    logic [7:0]  sram_dq_out;
    logic [7:0]  sram_dq_in;
    logic        sram_dq_oe;
    logic        sram_nce;
    logic        sram_noe;
    logic        sram_nwe;

    tiny32_sram_responder #(.SRAM_ABITS(19), .WAIT_CYCLES(1)) dut (
        .clk(clk), .nreset(nreset), .sel(sel), .address(address),
        .nrd(nrd), .nwr(nwr), .data_in(data_in), .data_out(data_out),
        .ready(ready), .sram_addr(sram_addr), .sram_dq_out(sram_dq_out),
        .sram_dq_in(sram_dq_in), .sram_dq_oe(sram_dq_oe), .sram_nce(sram_nce),
        .sram_noe(sram_noe), .sram_nwe(sram_nwe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0]  mem [0:4095];
    assign sram_dq_in = mem[sram_addr[11:0]];

    int          n_checks = 0;
    int          n_fail   = 0;
    int          rdy_cnt  = 0;
    int          nwe_cnt  = 0;
    logic        noe_seen = 1'b0;
    logic [31:0] exp_rd_q [$];
    logic [19:0] exp_wr_q [$];
    logic [18:0] addr_trace [$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    always @(posedge ready) rdy_cnt++;

    always @(negedge clk) begin
        if (sram_nce === 1'b0) addr_trace.push_back(sram_addr);
        if (sram_noe === 1'b0) noe_seen = 1'b1;
    end

    // Async SRAM write model: data taken on the nwe rising edge.
    always @(posedge sram_nwe) begin
        if (nreset === 1'b1 && sram_nce === 1'b0 && sram_dq_oe === 1'b1) begin
            logic [19:0] e;
            nwe_cnt++;
            mem[sram_addr[11:0]] = sram_dq_out;
            if (exp_wr_q.size() == 0) begin
                check("wr_unexpected", {12'd0, sram_addr[11:0], sram_dq_out}, 32'hFFFF_FFFF);
            end else begin
                e = exp_wr_q.pop_front();
                check("wr_addr", {20'd0, sram_addr[11:0]}, {20'd0, e[19:8]});
                check("wr_data", {24'd0, sram_dq_out}, {24'd0, e[7:0]});
            end
        end
    end

    // Drive one request at a negedge, wait for ready, score it, release strobes.
    task automatic do_req(input logic [31:0] addr, input logic rd_n, input logic [3:0] wr_n,
                          input logic [31:0] wdata, input int hold);
        logic [11:0] b;
        int          lat;
        int          rdy0;
        logic        is_rd;
        b     = addr[11:0] & 12'hFFC;
        is_rd = (wr_n == 4'hF);
        if (is_rd) begin
            exp_rd_q.push_back({mem[b+3], mem[b+2], mem[b+1], mem[b]});
        end else begin
            for (int i = 0; i < 4; i++)
                if (!wr_n[i]) exp_wr_q.push_back({b + 12'(i), wdata[8*i +: 8]});
        end
        rdy0    = rdy_cnt;
        sel     = 1'b1;
        address = addr;
        nrd     = rd_n;
        nwr     = wr_n;
        data_in = wdata;
        @(posedge clk);
        lat = 0;
        while (lat < 100) begin
            @(negedge clk);
            lat++;
            if (ready) break;
        end
        if (!ready) begin
            check("ready_timeout", 32'(lat), 32'(LATENCY + 1));
        end else begin
            check("latency", 32'(lat - 1), 32'(LATENCY));
            if (is_rd) check("read_data", data_out, exp_rd_q.pop_front());
        end
        @(negedge clk);
        check("ready_pulse_width", {31'd0, ready}, 32'd0);
        repeat (hold) @(negedge clk);
        sel = 1'b0;
        nrd = 1'b1;
        nwr = 4'hF;
        repeat (3) @(negedge clk);
        check("ready_count", 32'(rdy_cnt - rdy0), 32'd1);
    endtask

    initial begin
        logic [31:0] last_rd;
        int          nwe0;
        int          rdy0;
        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 7 + 3);
        mem[12'h100] = 8'h11; mem[12'h101] = 8'h22; mem[12'h102] = 8'h33; mem[12'h103] = 8'h44;
        mem[12'h200] = 8'h10; mem[12'h201] = 8'h20; mem[12'h202] = 8'h30; mem[12'h203] = 8'h40;
        nreset  = 1'b0;
        sel     = 1'b1;
        address = 32'd0;
        nrd     = 1'b1;
        nwr     = 4'hF;
        data_in = 32'd0;
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (10) @(negedge clk);

        check("idle_ready_cnt", 32'(rdy_cnt), 32'd0);
        check("idle_ctrl", {28'd0, sram_nce, sram_noe, sram_nwe, sram_dq_oe}, 32'hE);
        check("idle_data_out", data_out, 32'd0);
        check("idle_sram_addr", {13'd0, sram_addr}, 32'd0);
        check("idle_no_activity", 32'(addr_trace.size()), 32'd0);

        // Read 0x100 and check the byte address walk.
        addr_trace.delete();
        do_req(32'h100, 1'b0, 4'hF, 32'd0, 0);
        check("trace_len", 32'(addr_trace.size()), 32'(4 * S));
        for (int i = 0; i < addr_trace.size() && i < 4 * S; i++)
            check("trace_addr", {13'd0, addr_trace[i]}, 32'h100 + 32'(i / S));
        last_rd = 32'h44332211;
        check("read_0x100_value", data_out, last_rd);

        // Low address bits do not change lane order.
        do_req(32'h103, 1'b0, 4'hF, 32'd0, 0);

        // Partial-lane write.
        nwe0     = nwe_cnt;
        noe_seen = 1'b0;
        do_req(32'h200, 1'b1, 4'b1010, 32'hAABBCCDD, 0);
        check("write_nwe_pulses", 32'(nwe_cnt - nwe0), 32'd2);
        check("write_noe_idle", {31'd0, noe_seen}, 32'd0);
        check("write_lane1_kept", {24'd0, mem[12'h201]}, 32'h20);
        check("write_lane3_kept", {24'd0, mem[12'h203]}, 32'h40);
        check("write_data_out_kept", data_out, last_rd);
        do_req(32'h200, 1'b0, 4'hF, 32'd0, 0);
        check("readback_0x200", data_out, 32'h40BB20DD);

        // Held read strobe must not retrigger, then a fresh request runs.
        addr_trace.delete();
        do_req(32'h100, 1'b0, 4'hF, 32'd0, 20);
        check("held_single_access", 32'(addr_trace.size()), 32'(4 * S));
        do_req(32'h100, 1'b0, 4'hF, 32'd0, 0);

        // Read and write strobes together: write wins.
        noe_seen = 1'b0;
        do_req(32'h300, 1'b0, 4'b1110, 32'h0000005A, 0);
        check("rw_noe_idle", {31'd0, noe_seen}, 32'd0);
        check("rw_byte0", {24'd0, mem[12'h300]}, 32'h5A);

        // Reset in the middle of a read.
        rdy0    = rdy_cnt;
        sel     = 1'b1;
        address = 32'h100;
        nrd     = 1'b0;
        nwr     = 4'hF;
        @(posedge clk);
        repeat (5) @(posedge clk);
        #1 nreset = 1'b0;
        #1;
        check("rst_ctrl", {28'd0, sram_nce, sram_noe, sram_nwe, sram_dq_oe}, 32'hE);
        check("rst_ready", {31'd0, ready}, 32'd0);
        check("rst_data_out", data_out, 32'd0);
        @(negedge clk);
        sel = 1'b0;
        nrd = 1'b1;
        @(negedge clk);
        nreset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_no_ready", 32'(rdy_cnt - rdy0), 32'd0);
        do_req(32'h100, 1'b0, 4'hF, 32'd0, 0);

        // Not selected: nothing happens.
        rdy0 = rdy_cnt;
        addr_trace.delete();
        sel  = 1'b0;
        nrd  = 1'b0;
        repeat (20) @(negedge clk);
        nrd  = 1'b1;
        repeat (2) @(negedge clk);
        check("nosel_activity", 32'(addr_trace.size()), 32'd0);
        check("nosel_ready", 32'(rdy_cnt - rdy0), 32'd0);

        check("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);
        check("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
